fir_seq_filter: RTL and testbench
=================================

FIR_SEQ_FILTER -- requirements
Module: fir_seq_filter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, signed sample and coefficient width.
REQ-002 The block SHALL have parameter NOF_COEFF, default 12, number of taps (range 2..64).
REQ-003 The block SHALL have parameter OUT_WIDTH, default 20, signed output width.
REQ-004 The block SHALL have parameter OUT_SHIFT, default 0, arithmetic right shift applied to the accumulator before saturation.
REQ-005 The block SHALL have derived constant ACC_WIDTH = 2*DATA_WIDTH + clog2(NOF_COEFF), not overridable.
REQ-006 The block SHALL have ports, one per line:
 clk  in  1  single clock, all logic rising-edge.
 rst  in  1  synchronous, active-high reset.
 coeff_wr_en  in  1  coefficient write strobe.
 coeff_addr  in  clog2(NOF_COEFF)  tap index.
 coeff_data  in  DATA_WIDTH  signed coefficient.
 coeff_err  out  1  one-cycle pulse: write rejected.
 in_valid  in  1  sample valid.
 in_ready  out  1  block accepts sample.
 in_data  in  DATA_WIDTH  signed sample.
 out_valid  out  1  result valid.
 out_ready  in  1  downstream accepts result.
 out_data  out  OUT_WIDTH  signed filter result.
 out_sat  out  1  out_data was clipped; qualified by out_valid.
 busy  out  1  high in MAC or OUT state.
REQ-007 The block SHALL use one clock and a synchronous, active-high reset, rst, sampled on the rising edge of clk.

Function
REQ-008 The block SHALL implement a time-multiplexed FIR using one multiplier-accumulator: y[n] = sum over i=0..NOF_COEFF-1 of c[i]*x[n-i].
REQ-009 The FSM SHALL have states IDLE, MAC, OUT; in_ready = 1 only in IDLE.
REQ-010 In IDLE, an accept (in_valid & in_ready) SHALL shift in_data into delay-line slot x[0] (older samples move to x[i+1], oldest dropped), clear accumulator and tap counter, and go to MAC.
REQ-011 In MAC, each cycle SHALL add c[k]*x[k] (full-precision signed product, sign-extended to ACC_WIDTH) to the accumulator and increment k; after k = NOF_COEFF-1 the FSM SHALL go to OUT.
REQ-012 On entry to OUT, out_data SHALL be registered as (acc >>> OUT_SHIFT) saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], and out_sat SHALL be set if clipping occurred.
REQ-013 out_valid SHALL rise exactly NOF_COEFF+1 cycles after the accept cycle (13 for defaults).
REQ-014 In OUT, out_valid SHALL stay high and out_data/out_sat SHALL stay stable until out_valid & out_ready; that cycle returns to IDLE, so in_ready is high the following cycle.
REQ-015 Throughput SHALL be one sample per NOF_COEFF+2 cycles with out_ready held high.
REQ-016 A coefficient write with coeff_wr_en=1 in IDLE SHALL update c[coeff_addr] at the clock edge; it takes effect for samples accepted in the next or later cycles.
REQ-017 A coefficient write in MAC or OUT, or with coeff_addr >= NOF_COEFF, SHALL be ignored and coeff_err SHALL pulse high for one cycle.
REQ-018 A write and an accept in the same IDLE cycle SHALL both occur; the accepted sample SHALL use the updated coefficient.
REQ-019 The accumulator SHALL never overflow (guaranteed by ACC_WIDTH); only output saturation applies.

Reset
REQ-020 With rst high, at the next edge: FSM = IDLE, all delay-line slots = 0, all coefficients = 0, accumulator = 0, k = 0.
REQ-021 Output reset values: in_ready=1 the cycle after reset, out_valid=0, out_data=0, out_sat=0, coeff_err=0, busy=0.
REQ-022 Reset SHALL override any in-progress MAC or OUT state; the partial result is discarded and never presented.

Verification
REQ-023 Impulse: defaults, c[i]=i+1, send 1 then eleven 0s, out_ready=1 -> out_data sequence 1,2,...,12, then 0 for further zero samples, out_sat=0.
REQ-024 Latency/throughput: accept at cycle T -> out_valid first high at T+13; next in_ready at T+14; back-to-back samples accepted every 14 cycles.
REQ-025 Saturation: OUT_WIDTH=12, all c[i]=-128, twelve samples -128 -> raw 196608, out_data=2047, out_sat=1; with all c[i]=127 and samples -128 -> out_data=-2048, out_sat=1.
REQ-026 Backpressure: out_ready low 5 cycles after out_valid -> out_data/out_valid stable, in_ready=0, in_valid ignored; out_ready high -> handshake, in_ready=1 next cycle.
REQ-027 Illegal write: coeff write during MAC, and write to addr 12 in IDLE -> coeff_err one-cycle pulse each, coefficient array unchanged (impulse response identical).
REQ-028 Reset mid-MAC: rst at cycle 5 of MAC -> out_valid never rises for that sample, in_ready=1 after reset, subsequent impulse produces all zeros (coefficients cleared).

Source files
------------

// File: rtl/fir_seq_filter.sv
// Time-multiplexed FIR filter: one multiply-accumulate per cycle over NOF_COEFF taps,
// with a runtime-writable coefficient bank and a saturating, shifted output.
module fir_seq_filter #(
    parameter int DATA_WIDTH = 8,
    parameter int NOF_COEFF  = 12,
    parameter int OUT_WIDTH  = 20,
    parameter int OUT_SHIFT  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          coeff_wr_en,
    input  logic [$clog2(NOF_COEFF)-1:0]  coeff_addr,
    input  logic signed [DATA_WIDTH-1:0]  coeff_data,
    output logic                          coeff_err,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic                          out_sat,
    output logic                          busy
);

    localparam int AW        = $clog2(NOF_COEFF);
    localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(NOF_COEFF);
    localparam int PW        = 2 * DATA_WIDTH;
    // Compare width wide enough for both the accumulator and the output limits.
    localparam int CW        = (ACC_WIDTH > OUT_WIDTH ? ACC_WIDTH : OUT_WIDTH) + 1;

    localparam logic [AW-1:0] LAST_TAP    = AW'(NOF_COEFF - 1);
    localparam logic [AW:0]   NOF_COEFF_W = (AW + 1)'(NOF_COEFF);
    localparam logic signed [CW-1:0] SAT_MAX =
        {{(CW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [CW-1:0] SAT_MIN =
        {{(CW - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e                        state_q;
    logic signed [DATA_WIDTH-1:0]  coeff_q [NOF_COEFF];
    logic signed [DATA_WIDTH-1:0]  x_q     [NOF_COEFF];
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic signed [ACC_WIDTH-1:0]   acc_d;
    logic [AW-1:0]                 k_q;
    logic signed [PW-1:0]          prod;
    logic signed [ACC_WIDTH-1:0]   acc_shifted;
    logic signed [CW-1:0]          acc_wide;
    logic                          sat_hi;
    logic                          sat_lo;
    logic                          addr_ok;

    always_comb begin
        prod        = coeff_q[k_q] * x_q[k_q];
        acc_d       = acc_q + {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};
        acc_shifted = acc_d >>> OUT_SHIFT;
        acc_wide    = {{(CW - ACC_WIDTH){acc_shifted[ACC_WIDTH-1]}}, acc_shifted};
        sat_hi      = acc_wide > SAT_MAX;
        sat_lo      = acc_wide < SAT_MIN;
        addr_ok     = {1'b0, coeff_addr} < NOF_COEFF_W;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            k_q       <= '0;
            coeff_err <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            for (int i = 0; i < NOF_COEFF; i++) begin
                coeff_q[i] <= '0;
                x_q[i]     <= '0;
            end
        end else begin
            coeff_err <= coeff_wr_en && ((state_q != StIdle) || !addr_ok);
            if (coeff_wr_en && (state_q == StIdle) && addr_ok) begin
                coeff_q[coeff_addr] <= coeff_data;
            end

            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        x_q[0] <= in_data;
                        for (int i = 1; i < NOF_COEFF; i++) begin
                            x_q[i] <= x_q[i-1];
                        end
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 1'b1;
                    // Result is taken from acc_d so the last product is included.
                    if (k_q == LAST_TAP) begin
                        state_q  <= StOut;
                        out_sat  <= sat_hi || sat_lo;
                        out_data <= sat_hi ? SAT_MAX[OUT_WIDTH-1:0] :
                                    sat_lo ? SAT_MIN[OUT_WIDTH-1:0] :
                                             acc_wide[OUT_WIDTH-1:0];
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fir_seq_filter.sv
// Drives a default-width and a 12-bit-output filter in parallel and compares both
// against a plain convolution model with output clipping.
module tb_fir_seq_filter;

    localparam int DW  = 8;
    localparam int NC  = 12;
    localparam int OWA = 20;
    localparam int OWB = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 coeff_wr_en;
    logic [3:0]           coeff_addr;
    logic signed [DW-1:0] coeff_data;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 out_ready;

    logic                  coeff_err_a, in_ready_a, out_valid_a, out_sat_a, busy_a;
    logic signed [OWA-1:0] out_data_a;
    logic                  coeff_err_b, in_ready_b, out_valid_b, out_sat_b, busy_b;
    logic signed [OWB-1:0] out_data_b;

    fir_seq_filter #(.DATA_WIDTH(DW), .NOF_COEFF(NC), .OUT_WIDTH(OWA), .OUT_SHIFT(0)) dut_a (
        .clk(clk), .rst(rst), .coeff_wr_en(coeff_wr_en), .coeff_addr(coeff_addr),
        .coeff_data(coeff_data), .coeff_err(coeff_err_a), .in_valid(in_valid),
        .in_ready(in_ready_a), .in_data(in_data), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .out_sat(out_sat_a), .busy(busy_a)
    );

    fir_seq_filter #(.DATA_WIDTH(DW), .NOF_COEFF(NC), .OUT_WIDTH(OWB), .OUT_SHIFT(0)) dut_b (
        .clk(clk), .rst(rst), .coeff_wr_en(coeff_wr_en), .coeff_addr(coeff_addr),
        .coeff_data(coeff_data), .coeff_err(coeff_err_b), .in_valid(in_valid),
        .in_ready(in_ready_b), .in_data(in_data), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .out_sat(out_sat_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: coefficient bank and sample history, newest first.
    int coef_m [NC];
    int hist_m [NC];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint clip(input longint v, input int w);
        longint hi = (longint'(1) << (w - 1)) - 1;
        longint lo = -hi - 1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic int rnd8();
        logic signed [7:0] v = 8'($urandom);
        return int'(v);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NC; i++) begin
            coef_m[i] = 0;
            hist_m[i] = 0;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", in_ready_a, 1);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_data", out_data_a, 0);
        check("rst_out_sat", out_sat_a, 0);
        check("rst_coeff_err", coeff_err_a, 0);
        check("rst_busy", busy_a, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_model();
        check_reset_outputs();
    endtask

    task automatic write_coeff(input int addr, input int data);
        coeff_wr_en = 1'b1;
        coeff_addr  = 4'(addr);
        coeff_data  = 8'(data);
        step();
        coeff_wr_en = 1'b0;
        if (addr < NC) coef_m[addr] = data;
        check("coeff_err_idle", coeff_err_a, (addr >= NC) ? 1 : 0);
    endtask

    task automatic send(input int x, input int hold, input bit wr_same, input int wa,
                        input int wd, input bit wr_mac, output longint got_a,
                        output longint got_b);
        longint exp;
        int n;
        logic signed [OWA-1:0] da;
        logic signed [OWB-1:0] db;
        check("in_ready_idle", in_ready_a, 1);
        in_valid  = 1'b1;
        in_data   = 8'(x);
        out_ready = (hold == 0);
        if (wr_same) begin
            coeff_wr_en = 1'b1;
            coeff_addr  = 4'(wa);
            coeff_data  = 8'(wd);
        end
        step();
        coeff_wr_en = 1'b0;
        if (wr_same) begin
            if (wa < NC) coef_m[wa] = wd;
            check("coeff_err_same", coeff_err_a, (wa >= NC) ? 1 : 0);
        end
        for (int i = NC - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
        hist_m[0] = x;
        exp = 0;
        for (int i = 0; i < NC; i++) exp += longint'(coef_m[i]) * longint'(hist_m[i]);
        check("busy_mac", busy_a, 1);
        check("in_ready_mac", in_ready_a, 0);
        // Keep offering samples while busy; none may be taken.
        in_data = 8'(rnd8());
        n = 0;
        while (!out_valid_a && n < 40) begin
            if (wr_mac && n == 2) begin
                coeff_wr_en = 1'b1;
                coeff_addr  = 4'($urandom_range(0, NC - 1));
                coeff_data  = 8'(rnd8());
            end
            step();
            n++;
            if (wr_mac && n == 3) begin
                coeff_wr_en = 1'b0;
                check("coeff_err_mac", coeff_err_a, 1);
            end
            if (wr_mac && n == 4) check("coeff_err_pulse", coeff_err_a, 0);
        end
        check("latency", n, NC);
        check("out_valid_b", out_valid_b, 1);
        check("out_data_a", out_data_a, clip(exp, OWA));
        check("out_sat_a", out_sat_a, (clip(exp, OWA) != exp) ? 1 : 0);
        check("out_data_b", out_data_b, clip(exp, OWB));
        check("out_sat_b", out_sat_b, (clip(exp, OWB) != exp) ? 1 : 0);
        got_a = out_data_a;
        got_b = out_data_b;
        da = out_data_a;
        db = out_data_b;
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_valid", out_valid_a, 1);
            check("hold_data_a", out_data_a, da);
            check("hold_data_b", out_data_b, db);
            check("hold_in_ready", in_ready_a, 0);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_hs_in_ready", in_ready_a, 1);
        check("post_hs_out_valid", out_valid_a, 0);
    endtask

    task automatic impulse(input string tag, input bit zero_resp);
        longint ga, gb;
        for (int i = 0; i < NC + 2; i++) begin
            send((i == 0) ? 1 : 0, 0, 1'b0, 0, 0, (i == 0), ga, gb);
            check(tag, ga, (zero_resp || i >= NC) ? 0 : i + 1);
        end
    endtask

    initial begin
        longint ga, gb;
        bit seen_valid;
        rst = 1'b0; coeff_wr_en = 1'b0; coeff_addr = '0; coeff_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        step();
        do_reset();

        for (int i = 0; i < NC; i++) write_coeff(i, i + 1);
        impulse("impulse", 1'b0);

        // Out-of-range write and write-while-busy must leave the bank intact.
        write_coeff(12, 55);
        send(0, 5, 1'b0, 0, 0, 1'b0, ga, gb);
        impulse("impulse_after_bad_wr", 1'b0);

        for (int i = 0; i < NC; i++) write_coeff(i, -128);
        for (int i = 0; i < NC; i++) send(-128, 0, 1'b0, 0, 0, 1'b0, ga, gb);
        check("sat_pos_raw_a", ga, 196608);
        check("sat_pos_b", gb, 2047);
        check("sat_pos_flag_b", out_sat_b, 1);
        for (int i = 0; i < NC; i++) write_coeff(i, 127);
        for (int i = 0; i < NC; i++) send(-128, 0, 1'b0, 0, 0, 1'b0, ga, gb);
        check("sat_neg_raw_a", ga, -195072);
        check("sat_neg_b", gb, -2048);

        send(5, 0, 1'b1, 0, 3, 1'b0, ga, gb);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) write_coeff($urandom_range(0, 15), rnd8());
            send(rnd8(), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15), rnd8(), 1'($urandom_range(0, 1)), ga, gb);
        end

        // Reset five cycles into MAC: the partial result must never appear.
        in_valid = 1'b1;
        in_data  = 8'(rnd8());
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("mid_mac_busy", busy_a, 1);
        do_reset();
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid_a) seen_valid = 1'b1;
        end
        check("no_valid_after_rst", seen_valid, 0);
        impulse("impulse_after_rst", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
